spi_instr_decoder: RTL and testbench
====================================

// Module: spi_instr_decoder
// PURPOSE
//  Initiator side of the register-bus: turns the byte stream from the SPI byte layer into
//  read/write strobes toward the PWM register file, and returns read data for shift-out.
//  One instruction byte per frame, then a burst of data/dummy bytes. Sits between spi_bridge and regs.
// PARAMETERS
//  ADDR_W   6   register address width; burst address wraps modulo 2**ADDR_W
//  DATA_W   8   register/byte width
//  MIN_GAP  3   minimum clk cycles between rx_valid pulses; a closer pulse is an overrun
// PORTS
//  clk           in   1       peripheral clock, all logic on posedge
//  rst           in   1       asynchronous, active-high reset
//  frame_active  in   1       high while SPI chip-select is asserted (sync to clk)
//  rx_data       in   DATA_W  received byte, valid with rx_valid
//  rx_valid      in   1       one-cycle pulse per received byte
//  tx_data       out  DATA_W  byte to shift out on next SPI byte
//  tx_load       out  1       one-cycle pulse: tx_data is new
//  read          out  1       one-cycle read strobe to regs
//  write         out  1       one-cycle write strobe to regs
//  addr          out  ADDR_W  register address, stable while read/write high
//  data_write    out  DATA_W  write data, stable while write high
//  data_read     in   DATA_W  combinational read data from regs (valid same cycle as read)
//  busy          out  1       high in any state other than IDLE
//  err           out  1       sticky overrun flag
// BEHAVIOUR
//  Reset: all outputs 0, FSM -> IDLE, addr pointer 0. Reset mid-burst aborts; no strobe after rst.
//  Instruction byte: bit7 RW (1=write), bit6 INC (1=auto-increment), bits5:0 start address.
//  FSM: IDLE -(frame_active rise)-> CMD; clears err on that edge.
//   CMD -(rx_valid)-> latch addr/RW/INC; RW=1 -> WR_DATA; RW=0 -> RD_ISSUE.
//   WR_DATA: each rx_valid at cycle N -> write=1, data_write=rx_data, addr=ptr at N+1;
//     after strobe ptr += INC (wrap 2**ADDR_W-1 -> 0). INC=0 rewrites same address.
//   RD_ISSUE: read=1 one cycle; data_read captured into tx_data that cycle; tx_load=1 next
//     cycle (instruction rx_valid at N -> read at N+1 -> tx_load at N+2). -> RD_WAIT.
//   RD_WAIT: each rx_valid (dummy byte, content ignored) -> ptr += INC, -> RD_ISSUE (prefetch).
//   Any state -(frame_active low)-> IDLE next cycle; outstanding 1-cycle strobe completes.
//  Simultaneous rx_valid and frame_active fall: byte is processed, then IDLE.
//  Overrun: rx_valid < MIN_GAP cycles after previous -> byte dropped, err=1 until next frame.
//  rx_valid in IDLE is ignored (no strobe, no err). read and write never high together.
//  tx_data holds last value between loads; 0x00 after reset.
// STRUCTURE
//  Shared include (pwm_bus_defs.vh): instruction bit positions (RW=7, INC=6), ADDR_W/DATA_W
//  defaults, FSM state encodings. Single module; no sub-module — FSM, address pointer and
//  gap counter are small enough to live together. Gap counter saturates at MIN_GAP.
// TESTING
//  Write burst: frame, bytes 0xC3,0x11,0x22 -> write@0x03=0x11, write@0x04=0x22, no read.
//  Read burst: regs 0x0A=0x5A,0x0B=0x01; bytes 0x4A,0xFF -> read@0x0A, tx_data=0x5A (tx_load at N+2),
//   then read@0x0B, tx_data=0x01.
//  Wrap: bytes 0xFF,0xAA,0xBB -> write@0x3F=0xAA then write@0x00=0xBB.
//  No-INC: bytes 0x82,0x01,0x00 -> two writes both @0x02 (0x01 then 0x00).
//  Overrun: two rx_valid 1 cycle apart -> second dropped, err=1; next frame rise -> err=0.
//  Abort: rst high between instruction and data byte -> all outputs 0, no write strobe ever issued.

Source files
------------

// File: rtl/spi_instr_decoder_pkg.sv
// Shared definitions for the SPI instruction decoder: instruction layout,
// default widths and FSM state encodings.
package spi_instr_decoder_pkg;

    localparam int ADDR_W_DEF  = 6;
    localparam int DATA_W_DEF  = 8;
    localparam int MIN_GAP_DEF = 3;

    localparam int INSTR_RW_BIT  = 7;
    localparam int INSTR_INC_BIT = 6;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CMD      = 3'd1;
    localparam logic [2:0] ST_WR_DATA  = 3'd2;
    localparam logic [2:0] ST_RD_ISSUE = 3'd3;
    localparam logic [2:0] ST_RD_WAIT  = 3'd4;

    typedef struct packed {
        logic rw;
        logic inc;
    } instr_flags_t;

    function automatic instr_flags_t get_flags(input logic [7:0] instr);
        instr_flags_t f;
        f.rw  = instr[INSTR_RW_BIT];
        f.inc = instr[INSTR_INC_BIT];
        return f;
    endfunction

endpackage

// File: rtl/spi_instr_decoder.sv
// Register-bus initiator: decodes one instruction byte per SPI frame, then
// issues write strobes per data byte or prefetching reads per dummy byte.
module spi_instr_decoder
    import spi_instr_decoder_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MIN_GAP = MIN_GAP_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_active,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_load,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_write,
    input  logic [DATA_W-1:0] data_read,
    output logic              busy,
    output logic              err
);

    localparam int GAP_W = $clog2(MIN_GAP + 1);

    logic [2:0]        state, state_nxt;
    logic              frame_q;
    logic [GAP_W-1:0]  gap_cnt;
    logic              inc_q;
    logic [ADDR_W-1:0] ptr;
    logic              frame_rise, in_frame, overrun, accept;
    instr_flags_t      flags;

    assign frame_rise = frame_active & ~frame_q;
    assign in_frame   = (state != ST_IDLE);
    assign overrun    = rx_valid & in_frame & (gap_cnt < GAP_W'(MIN_GAP));
    assign accept     = rx_valid & in_frame & ~overrun;
    assign flags      = get_flags(rx_data[7:0]);

    assign read  = (state == ST_RD_ISSUE);
    assign busy  = in_frame;
    assign addr  = ptr;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (frame_rise) state_nxt = ST_CMD;
            ST_CMD:      if (accept) state_nxt = flags.rw ? ST_WR_DATA : ST_RD_ISSUE;
            ST_WR_DATA:  state_nxt = ST_WR_DATA;
            ST_RD_ISSUE: state_nxt = ST_RD_WAIT;
            ST_RD_WAIT:  if (accept) state_nxt = ST_RD_ISSUE;
            default:     state_nxt = ST_IDLE;
        endcase
        // A byte arriving with the frame fall is still acted on, but the frame ends.
        if (in_frame && !frame_active) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            frame_q    <= 1'b0;
            gap_cnt    <= GAP_W'(MIN_GAP);
            inc_q      <= 1'b0;
            ptr        <= '0;
            err        <= 1'b0;
            write      <= 1'b0;
            data_write <= '0;
            tx_load    <= 1'b0;
            tx_data    <= '0;
        end else begin
            state   <= state_nxt;
            frame_q <= frame_active;

            // Counts cycles since the last pulse, dropped pulses included.
            if (!in_frame && frame_rise)
                gap_cnt <= GAP_W'(MIN_GAP);
            else if (rx_valid && in_frame)
                gap_cnt <= GAP_W'(1);
            else if (gap_cnt < GAP_W'(MIN_GAP))
                gap_cnt <= gap_cnt + GAP_W'(1);

            if (!in_frame && frame_rise)
                err <= 1'b0;
            else if (overrun)
                err <= 1'b1;

            write <= accept && (state == ST_WR_DATA);
            if (accept && state == ST_WR_DATA)
                data_write <= rx_data;

            // Write pointer advances after its strobe; read pointer before the prefetch.
            if (accept && state == ST_CMD) begin
                ptr   <= rx_data[ADDR_W-1:0];
                inc_q <= flags.inc;
            end else if (write || (accept && state == ST_RD_WAIT)) begin
                ptr <= ptr + ADDR_W'(inc_q);
            end

            tx_load <= (state == ST_RD_ISSUE);
            if (state == ST_RD_ISSUE)
                tx_data <= data_read;
        end
    end

endmodule

// File: tb/tb_spi_instr_decoder.sv
// Self-checking bench for spi_instr_decoder: table-driven frames plus
// hand-written overrun, frame-fall and reset-abort sequences.
module tb_spi_instr_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_active;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       read;
    logic       write;
    logic [5:0] addr;
    logic [7:0] data_write;
    logic [7:0] data_read;
    logic       busy;
    logic       err;

    logic [7:0] mem [64];

    spi_instr_decoder dut (
        .clk(clk), .rst(rst), .frame_active(frame_active),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_load(tx_load),
        .read(read), .write(write), .addr(addr),
        .data_write(data_write), .data_read(data_read),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;
    assign data_read = mem[addr];

    localparam logic [1:0] K_W = 2'd1, K_R = 2'd2, K_T = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [5:0] a;
        logic [7:0] d;
    } ev_t;

    typedef struct packed {
        logic [3:0][7:0] b;
        logic [2:0]      nb;
        ev_t  [3:0]      ev;
        logic [2:0]      nev;
    } vec_t;

    ev_t  exp_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_mis++;
            $display("FAIL %s: got %0h, want %0h", name, act, expv);
        end
    endtask

    function automatic ev_t mk_ev(input logic [1:0] k, input logic [5:0] a, input logic [7:0] d);
        ev_t e;
        e.kind = k; e.a = a; e.d = d;
        return e;
    endfunction

    function automatic vec_t mk_vec(input logic [7:0] b0, b1, b2, input int nb,
                                    input ev_t e0, e1, e2, e3, input int nev);
        vec_t v;
        v.b   = {8'h00, b2, b1, b0};
        v.nb  = 3'(nb);
        v.ev  = {e3, e2, e1, e0};
        v.nev = 3'(nev);
        return v;
    endfunction

    task automatic pop_cmp(input logic [1:0] k, input logic [5:0] a, input logic [7:0] d,
                           input string nm);
        ev_t e;
        if (exp_q.size() == 0) begin
            check({nm, "_unexpected"}, 32'({k, a, d}), 32'h0);
        end else begin
            e = exp_q.pop_front();
            check(nm, 32'({k, a, d}), 32'(e));
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (read || write) check("rw_exclusive", 32'(read & write), 32'h0);
            if (write)   pop_cmp(K_W, addr, data_write, "write_strobe");
            if (read)    pop_cmp(K_R, addr, 8'h00, "read_strobe");
            if (tx_load) pop_cmp(K_T, 6'h00, tx_data, "tx_load");
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Pulse one byte; next byte may follow 4 cycles later (>= MIN_GAP).
    task automatic drive_byte(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        cyc(1);
        rx_valid = 1'b0;
        cyc(3);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        for (int i = 0; i < int'(v.nev); i++) exp_q.push_back(v.ev[i]);
        frame_active = 1'b1;
        cyc(2);
        check($sformatf("vec%0d_busy", idx), 32'(busy), 32'h1);
        for (int i = 0; i < int'(v.nb); i++) drive_byte(v.b[i]);
        cyc(4);
        frame_active = 1'b0;
        cyc(3);
        check($sformatf("vec%0d_drained", idx), 32'(exp_q.size()), 32'h0);
        check($sformatf("vec%0d_idle", idx), 32'(busy), 32'h0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'(i) ^ 8'h80;
        mem[6'h0A] = 8'h5A;
        mem[6'h0B] = 8'h01;

        vecs[0] = mk_vec(8'hC3, 8'h11, 8'h22, 3, mk_ev(K_W, 6'h03, 8'h11), mk_ev(K_W, 6'h04, 8'h22), '0, '0, 2);
        vecs[1] = mk_vec(8'h4A, 8'hFF, 8'h00, 2, mk_ev(K_R, 6'h0A, 8'h00), mk_ev(K_T, 6'h00, 8'h5A),
                         mk_ev(K_R, 6'h0B, 8'h00), mk_ev(K_T, 6'h00, 8'h01), 4);
        vecs[2] = mk_vec(8'hFF, 8'hAA, 8'hBB, 3, mk_ev(K_W, 6'h3F, 8'hAA), mk_ev(K_W, 6'h00, 8'hBB), '0, '0, 2);
        vecs[3] = mk_vec(8'h82, 8'h01, 8'h00, 3, mk_ev(K_W, 6'h02, 8'h01), mk_ev(K_W, 6'h02, 8'h00), '0, '0, 2);
        vecs[4] = mk_vec(8'h0A, 8'h00, 8'h00, 2, mk_ev(K_R, 6'h0A, 8'h00), mk_ev(K_T, 6'h00, 8'h5A),
                         mk_ev(K_R, 6'h0A, 8'h00), mk_ev(K_T, 6'h00, 8'h5A), 4);
        vecs[5] = mk_vec(8'h7F, 8'h00, 8'h00, 2, mk_ev(K_R, 6'h3F, 8'h00), mk_ev(K_T, 6'h00, 8'hBF),
                         mk_ev(K_R, 6'h00, 8'h00), mk_ev(K_T, 6'h00, 8'h80), 4);

        rst = 1'b1; frame_active = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        cyc(3);
        check("rst_tx_data", 32'(tx_data), 32'h0);
        check("rst_tx_load", 32'(tx_load), 32'h0);
        check("rst_read", 32'(read), 32'h0);
        check("rst_write", 32'(write), 32'h0);
        check("rst_addr", 32'(addr), 32'h0);
        check("rst_data_write", 32'(data_write), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        rst = 1'b0;
        cyc(2);

        // Byte outside a frame is ignored.
        drive_byte(8'hC0);
        check("idle_rx_err", 32'(err), 32'h0);
        check("idle_rx_busy", 32'(busy), 32'h0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Overrun: second data byte one cycle after the first is dropped.
        exp_q.push_back(mk_ev(K_W, 6'h05, 8'h33));
        frame_active = 1'b1;
        cyc(2);
        drive_byte(8'h85);
        rx_data = 8'h33; rx_valid = 1'b1;
        cyc(1);
        rx_data = 8'h44;
        cyc(1);
        rx_valid = 1'b0;
        cyc(4);
        check("overrun_err_set", 32'(err), 32'h1);
        frame_active = 1'b0;
        cyc(3);
        check("overrun_err_sticky", 32'(err), 32'h1);
        check("overrun_drained", 32'(exp_q.size()), 32'h0);
        frame_active = 1'b1;
        cyc(2);
        check("overrun_err_cleared", 32'(err), 32'h0);
        frame_active = 1'b0;
        cyc(3);
        exp_q.delete();

        // Byte coinciding with the frame fall is still written.
        exp_q.push_back(mk_ev(K_W, 6'h09, 8'h77));
        frame_active = 1'b1;
        cyc(2);
        drive_byte(8'hC9);
        rx_data = 8'h77; rx_valid = 1'b1; frame_active = 1'b0;
        cyc(1);
        rx_valid = 1'b0;
        check("fall_write", 32'(write), 32'h1);
        check("fall_busy", 32'(busy), 32'h0);
        cyc(3);
        check("fall_drained", 32'(exp_q.size()), 32'h0);
        exp_q.delete();

        // Reset between instruction and data byte aborts the burst.
        frame_active = 1'b1;
        cyc(2);
        drive_byte(8'hC7);
        rst = 1'b1; frame_active = 1'b0;
        cyc(1);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_write", 32'(write), 32'h0);
        check("abort_addr", 32'(addr), 32'h0);
        rx_data = 8'h55; rx_valid = 1'b1;
        cyc(1);
        rx_valid = 1'b0; rst = 1'b0;
        cyc(2);
        drive_byte(8'h66);
        check("abort_no_strobe", 32'(exp_q.size()), 32'h0);
        check("abort_idle", 32'(busy), 32'h0);
        check("abort_data_write", 32'(data_write), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
